// File: rtl/drum_machine_sm.sv
// Five-track, 16-step looping drum sequencer: a step FSM, set-only pattern recording and playback with a metronome overlay on track E.
// Optional build macro DRUM_LIVE_MONITOR_EN: while playing, pad hits are also heard at once on the track outputs.
module drum_machine_sm (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Ain,
  input  logic        Bin,
  input  logic        Cin,
  input  logic        Din,
  input  logic        Ein,
  input  logic        Fourths,
  input  logic        Eighths,
  output logic        playing,
  output logic        Aout,
  output logic        Bout,
  output logic        Cout,
  output logic        Dout,
  output logic        Eout,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [15:0] C,
  output logic [15:0] D,
  output logic [15:0] E,
  output logic [16:0] state
);

  typedef enum logic [0:0] {
    MODE_IDLE = 1'b0,
    MODE_PLAY = 1'b1
  } mode_e;

  mode_e       mode_q, mode_d;
  logic [3:0]  step_q, step_d;
  logic [15:0] a_q, b_q, c_q, d_q, e_q;
  logic [15:0] a_d, b_d, c_d, d_d, e_d;
  logic        rec_en_s;
  logic        met_s;
  logic        a_live_s, b_live_s, c_live_s, d_live_s, e_live_s;

  // Set the pattern bit at step k when a hit arrives during playback.
  function automatic logic [15:0] record_hit(input logic [15:0] pat, input logic hit,
                                             input logic en, input logic [3:0] k);
    logic [15:0] mask;
    mask = 16'h0001 << k;
    if (hit && en) begin
      record_hit = pat | mask;
    end else begin
      record_hit = pat;
    end
  endfunction

  // Next-state logic for the play mode and the step position.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    case (mode_q)
      MODE_IDLE: begin
        if (Start) begin
          mode_d = MODE_PLAY;
          step_d = 4'd0;
        end else begin
          mode_d = MODE_IDLE;
          step_d = 4'd0;
        end
      end
      MODE_PLAY: begin
        // Stop has priority over Start while playing.
        if (Stop) begin
          mode_d = MODE_IDLE;
          step_d = 4'd0;
        end else begin
          mode_d = MODE_PLAY;
          step_d = step_q + 4'd1;
        end
      end
      default: begin
        mode_d = MODE_IDLE;
        step_d = 4'd0;
      end
    endcase
  end

  // Pattern recording: pads only take effect while a step is active.
  always_comb begin
    rec_en_s = (mode_q == MODE_PLAY);
    a_d      = record_hit(a_q, Ain, rec_en_s, step_q);
    b_d      = record_hit(b_q, Bin, rec_en_s, step_q);
    c_d      = record_hit(c_q, Cin, rec_en_s, step_q);
    d_d      = record_hit(d_q, Din, rec_en_s, step_q);
    e_d      = record_hit(e_q, Ein, rec_en_s, step_q);
  end

  // State and pattern registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q <= MODE_IDLE;
      step_q <= 4'd0;
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      c_q    <= 16'h0000;
      d_q    <= 16'h0000;
      e_q    <= 16'h0000;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      d_q    <= d_d;
      e_q    <= e_d;
    end
  end

  // Optional live monitoring of pad hits.
  always_comb begin
`ifdef DRUM_LIVE_MONITOR_EN
    a_live_s = Ain;
    b_live_s = Bin;
    c_live_s = Cin;
    d_live_s = Din;
    e_live_s = Ein;
`else
    a_live_s = 1'b0;
    b_live_s = 1'b0;
    c_live_s = 1'b0;
    d_live_s = 1'b0;
    e_live_s = 1'b0;
`endif
  end

  // Playback decode, metronome overlay and the one-hot state view.
  always_comb begin
    playing = (mode_q == MODE_PLAY);
    if (playing) begin
      state = 17'h00002 << step_q;
    end else begin
      state = 17'h00001;
    end
    met_s = (Fourths && (step_q[1:0] == 2'b00)) || (Eighths && (step_q[0] == 1'b0));
    Aout  = playing & (a_q[step_q] | a_live_s);
    Bout  = playing & (b_q[step_q] | b_live_s);
    Cout  = playing & (c_q[step_q] | c_live_s);
    Dout  = playing & (d_q[step_q] | d_live_s);
    Eout  = playing & (e_q[step_q] | e_live_s | met_s);
    A     = a_q;
    B     = b_q;
    C     = c_q;
    D     = d_q;
    E     = e_q;
  end

endmodule

// File: tb/tb_drum_machine_sm.sv
// Directed bench for drum_machine_sm: a vector table for reset/start/record, then hand sequences for looping, metronome, stop and reset.
module tb_drum_machine_sm;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stop, Ain, Bin, Cin, Din, Ein, Fourths, Eighths;
  logic        playing, Aout, Bout, Cout, Dout, Eout;
  logic [15:0] A, B, C, D, E;
  logic [16:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_k    = 0;
  logic [15:0] mA, mB, mC, mD, mE;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        stop;
    logic [4:0]  pads;
    logic [16:0] e_state;
    logic        e_play;
    logic [4:0]  e_outs;
    logic [79:0] e_pat;
  } vec_t;

  vec_t vecs [10];

  drum_machine_sm dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Ain(Ain), .Bin(Bin), .Cin(Cin), .Din(Din), .Ein(Ein),
    .Fourths(Fourths), .Eighths(Eighths),
    .playing(playing), .Aout(Aout), .Bout(Bout), .Cout(Cout), .Dout(Dout), .Eout(Eout),
    .A(A), .B(B), .C(C), .D(D), .E(E), .state(state)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [16:0] st, input logic pl,
                           input logic [4:0] outs, input logic [79:0] pat);
    check({tag, " state"},   80'(state), 80'(st));
    check({tag, " playing"}, 80'(playing), 80'(pl));
    check({tag, " outs"},    80'({Aout, Bout, Cout, Dout, Eout}), 80'(outs));
    check({tag, " pattern"}, {A, B, C, D, E}, pat);
  endtask

  // Apply inputs across one rising edge, then release the one-shot inputs.
  task automatic drive(input logic rst, input logic st, input logic sp, input logic [4:0] pads);
    Reset = rst; Start = st; Stop = sp;
    {Ain, Bin, Cin, Din, Ein} = pads;
    @(posedge Clk);
    #1;
    Reset = 1'b0; Start = 1'b0; Stop = 1'b0;
    {Ain, Bin, Cin, Din, Ein} = 5'b00000;
    #1;
  endtask

  function automatic logic [4:0] model_outs(input int k);
    logic met;
    met = (Fourths && (k % 4 == 0)) || (Eighths && (k % 2 == 0));
    return {mA[k], mB[k], mC[k], mD[k], mE[k] | met};
  endfunction

  task automatic run_model(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 5'b00000);
      exp_k = (exp_k + 1) % 16;
      check_all(tag, 17'h00002 << exp_k, 1'b1, model_outs(exp_k), {mA, mB, mC, mD, mE});
    end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Stop = 1'b0; Fourths = 1'b0; Eighths = 1'b0;
    {Ain, Bin, Cin, Din, Ein} = 5'b00000;

    // rst start stop pads state play outs pattern{A,B,C,D,E}
    vecs[0] = '{1'b1, 1'b0, 1'b0, 5'b00000, 17'h00001, 1'b0, 5'b00000, 80'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 5'b00000, 17'h00001, 1'b0, 5'b00000, 80'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 5'b11111, 17'h00001, 1'b0, 5'b00000, 80'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 5'b00000, 17'h00002, 1'b1, 5'b00000, 80'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 5'b00000, 17'h00004, 1'b1, 5'b00000, 80'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 5'b00000, 17'h00008, 1'b1, 5'b00000, 80'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 5'b00000, 17'h00010, 1'b1, 5'b00000, 80'h0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 5'b00000, 17'h00020, 1'b1, 5'b00000, 80'h0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 5'b10000, 17'h00040, 1'b1, 5'b00000,
                {16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 5'b00110, 17'h00080, 1'b1, 5'b00000,
                {16'h0010, 16'h0000, 16'h0020, 16'h0020, 16'h0000}};

    // Leave the design in a non-idle state before the table's reset row.
    @(negedge Clk);
    drive(1'b0, 1'b1, 1'b0, 5'b11111);
    drive(1'b0, 1'b0, 1'b0, 5'b00000);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].pads);
      check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_play,
                vecs[i].e_outs, vecs[i].e_pat);
    end

    // Patterns recorded by the table: A[4], C[5], D[5]; now sitting in STEP6.
    mA = 16'h0010; mB = 16'h0000; mC = 16'h0020; mD = 16'h0020; mE = 16'h0000;
    exp_k = 6;
    run_model(96, "freerun");

    Eighths = 1'b1;
    run_model(48, "eighths");
    Eighths = 1'b0; Fourths = 1'b1;
    run_model(48, "fourths");
    Eighths = 1'b1;
    run_model(16, "both");

    // Metronome responds without a clock edge.
    Fourths = 1'b0; Eighths = 1'b0;
    #1;
    check("met_off", 80'(Eout), 80'(mE[exp_k]));
    Eighths = 1'b1;
    #1;
    check("met_comb", 80'(Eout), 80'((exp_k % 2) == 0));
    Eighths = 1'b0;
    #1;

    drive(1'b0, 1'b0, 1'b1, 5'b00000);
    check_all("stop", 17'h00001, 1'b0, 5'b00000, {mA, mB, mC, mD, mE});
    drive(1'b0, 1'b1, 1'b0, 5'b00000);
    exp_k = 0;
    check_all("restart", 17'h00002, 1'b1, model_outs(0), {mA, mB, mC, mD, mE});
    run_model(5, "replay");

    drive(1'b0, 1'b1, 1'b1, 5'b00000);
    check_all("both_play", 17'h00001, 1'b0, 5'b00000, {mA, mB, mC, mD, mE});
    drive(1'b0, 1'b1, 1'b1, 5'b00000);
    exp_k = 0;
    check_all("both_idle", 17'h00002, 1'b1, model_outs(0), {mA, mB, mC, mD, mE});

    drive(1'b0, 1'b0, 1'b0, 5'b00001);
    mE[0] = 1'b1; exp_k = 1;
    check_all("rec_e", 17'h00004, 1'b1, model_outs(1), {mA, mB, mC, mD, mE});
    drive(1'b0, 1'b0, 1'b0, 5'b01000);
    mB[1] = 1'b1; exp_k = 2;
    check_all("rec_b", 17'h00008, 1'b1, model_outs(2), {mA, mB, mC, mD, mE});
    run_model(16, "play_eb");

    drive(1'b1, 1'b1, 1'b0, 5'b11111);
    mA = 16'h0000; mB = 16'h0000; mC = 16'h0000; mD = 16'h0000; mE = 16'h0000;
    check_all("reset_mid", 17'h00001, 1'b0, 5'b00000, 80'h0);
    drive(1'b0, 1'b1, 1'b0, 5'b00000);
    exp_k = 0;
    check_all("after_reset", 17'h00002, 1'b1, 5'b00000, 80'h0);
    run_model(5, "cleared");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
